memory_burst_banked: RTL

//  Word-wide memory of NUM_MEM_UNITS byte lanes with per-lane write strobes and burst reads.
//  - Single request port with valid/ready handshake.
//  - Writes are single-beat and lane-masked.
//  - Reads stream 1..2^LEN_WIDTH consecutive words, one word per cycle, with address wrap.
//  - Sits between a bus master (CPU/DMA) and local storage.
//  - Successor to the single-lane memory unit: full-bus width, lane strobes, burst FSM, async reset.

---
 rtl/memory_burst_banked.sv | 119 +++++++++++
 1 files changed

// File: rtl/memory_burst_banked.sv
// Lane-strobed word memory with a valid/ready request port and gap-free burst reads.
// Reads have one cycle of latency and wrap around the address space.
module memory_burst_banked #(
  parameter int BUS_SIZE       = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int NUM_MEM_UNITS  = 4,
  parameter int LEN_WIDTH      = 3,
  parameter int MEM_LENGTH     = 1 << ADDR_WIDTH,
  parameter int MEM_UNIT_WIDTH = BUS_SIZE / NUM_MEM_UNITS
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [LEN_WIDTH-1:0]     req_len,
  input  logic [BUS_SIZE-1:0]      req_wdata,
  input  logic [NUM_MEM_UNITS-1:0] req_wstrb,
  output logic                     rd_valid,
  output logic [BUS_SIZE-1:0]      rd_data,
  output logic                     rd_last,
  output logic                     busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state_p1, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr_p1, ptr_nxt, rd_addr;
  logic [LEN_WIDTH-1:0]    rem_p1, rem_nxt;
  logic                    vld_p1, vld_nxt;
  logic                    last_p1, last_nxt;
  logic                    rd_en;
  logic [BUS_SIZE-1:0]     data_p1;
  logic                    accept;

  logic [BUS_SIZE-1:0]     mem [MEM_LENGTH];

  assign req_ready = (state_p1 == IDLE);
  assign busy      = (state_p1 == BURST);
  assign accept    = req_valid && req_ready;

  // Storage: per-lane write enables so each lane maps onto a byte-enable RAM column.
  always_ff @(posedge clk) begin
    if (accept && req_write) begin
      for (int i = 0; i < NUM_MEM_UNITS; i++) begin
        if (req_wstrb[i]) begin
          mem[req_addr][i*MEM_UNIT_WIDTH +: MEM_UNIT_WIDTH] <=
            req_wdata[i*MEM_UNIT_WIDTH +: MEM_UNIT_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state_p1;
    ptr_nxt   = ptr_p1;
    rem_nxt   = rem_p1;
    vld_nxt   = 1'b0;
    last_nxt  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = ptr_p1;
    case (state_p1)
      IDLE: begin
        if (accept && !req_write) begin
          rd_en    = 1'b1;
          rd_addr  = req_addr;
          vld_nxt  = 1'b1;
          last_nxt = (req_len == '0);
          if (req_len != '0) begin
            ptr_nxt   = req_addr + ADDR_WIDTH'(1);
            rem_nxt   = req_len - LEN_WIDTH'(1);
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        // Returning to IDLE on the last beat lets a new request land with no bubble.
        rd_en   = 1'b1;
        vld_nxt = 1'b1;
        ptr_nxt = ptr_p1 + ADDR_WIDTH'(1);
        if (rem_p1 == '0) begin
          last_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          rem_nxt = rem_p1 - LEN_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered read beat and burst control.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_p1 <= IDLE;
      ptr_p1   <= '0;
      rem_p1   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      data_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      ptr_p1   <= ptr_nxt;
      rem_p1   <= rem_nxt;
      vld_p1   <= vld_nxt;
      last_p1  <= last_nxt;
      if (rd_en) data_p1 <= mem[rd_addr];
    end
  end

  assign rd_valid = vld_p1;
  assign rd_last  = last_p1;
  assign rd_data  = data_p1;

endmodule
